// File: rtl/cpu_bus_pkg.sv
// Shared types for the bus transfer sequencer.
//   seq_state_e : sequencer FSM states
//   cmd_t       : queued transfer command, sized for the largest legal register count
//   BusWidth    : width of the internal data bus the sequenced registers share
package cpu_bus_pkg;

  localparam int unsigned BusWidth = 8;
  localparam int unsigned MaxRegs  = 16;
  localparam int unsigned MaxSrcW  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StLoad,
    StRelease
  } seq_state_e;

  // Fields are zero-extended when a block is built with fewer than MaxRegs registers.
  typedef struct packed {
    logic [MaxSrcW-1:0] src;
    logic [MaxRegs-1:0] dst;
  } cmd_t;

endpackage

// File: rtl/bus_transfer_sequencer_if.sv
// Command and strobe bundle of the bus transfer sequencer.
//   cmd_valid/cmd_ready : command handshake
//   cmd_src             : source register index
//   cmd_dst             : destination register bitmask
//   bus_enable/load     : per-register drive / capture strobes
//   busy/done/err       : status
// master = command issuer / strobe observer, slave = sequencer.
interface bus_transfer_sequencer_if #(
  parameter int unsigned NUM_REGS = 4
) ();

  localparam int unsigned SrcW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [SrcW-1:0]     cmd_src;
  logic [NUM_REGS-1:0] cmd_dst;
  logic [NUM_REGS-1:0] bus_enable;
  logic [NUM_REGS-1:0] load;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, bus_enable, load, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, bus_enable, load, busy, done, err
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with full/empty flags and asynchronous active-high reset.
//   clk, reset  : clock, async reset (empties the queue)
//   push, wdata : write strobe and data, ignored while full
//   pop, rdata  : read strobe and head data (rdata valid while !empty)
//   full, empty : occupancy flags
module cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AddrW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AddrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences register-to-register moves over the shared internal data bus.
//   clk, reset : clock, async active-high reset (strobes drop immediately)
//   bus        : slave side of bus_transfer_sequencer_if
//                cmd_valid/cmd_ready/cmd_src/cmd_dst in, bus_enable/load strobes out,
//                busy level, done and err single-cycle pulses
// Commands are validated on accept, queued in cmd_fifo and executed as
// DRIVE (SETTLE_CYCLES) -> LOAD (1) -> RELEASE (1, bus dead cycle).
module bus_transfer_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                      clk,
  input logic                      reset,
  bus_transfer_sequencer_if.slave  bus
);

  localparam int unsigned SrcW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [MaxSrcW-1:0] idx);
    onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [SrcW-1:0]     cmd_src;
  logic [NUM_REGS-1:0] cmd_dst;
  logic [MaxSrcW-1:0]  src_ext;
  logic                src_ok, dst_hits_src, cmd_invalid;
  logic                accept, push, pop;
  logic                fifo_full, fifo_empty;
  logic [$bits(cmd_t)-1:0] fifo_rdata;
  cmd_t                push_cmd, head;

  seq_state_e          state_q;
  logic [CntW-1:0]     cnt_q;
  logic [NUM_REGS-1:0] dst_q;
  logic [NUM_REGS-1:0] bus_enable_q, load_q;
  logic                done_q, err_q;

  assign cmd_src = bus.cmd_src;
  assign cmd_dst = bus.cmd_dst;
  assign src_ext = MaxSrcW'(cmd_src);

  // An out-of-range source shifts the one-hot out entirely, so dst_hits_src stays 0.
  assign src_ok       = 32'(src_ext) < NUM_REGS;
  assign dst_hits_src = |(cmd_dst & onehot(src_ext));
  assign cmd_invalid  = !src_ok || (cmd_dst == '0) || dst_hits_src;

  assign accept = bus.cmd_valid && !fifo_full;
  assign push   = accept && !cmd_invalid;
  assign pop    = !fifo_empty && ((state_q == StIdle) || (state_q == StRelease));

  always_comb begin
    push_cmd     = '0;
    push_cmd.src = src_ext;
    push_cmd.dst = MaxRegs'(cmd_dst);
  end

  assign head = cmd_t'(fifo_rdata);

  // Destination bits above NUM_REGS are always zero in the queue.
  logic unused_head_dst;
  assign unused_head_dst = ^head.dst;

  cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Strobes are registered alongside the state so every output comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dst_q        <= '0;
      bus_enable_q <= '0;
      load_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= accept && cmd_invalid;
      case (state_q)
        StIdle, StRelease: begin
          if (pop) begin
            state_q      <= StDrive;
            cnt_q        <= '0;
            dst_q        <= head.dst[NUM_REGS-1:0];
            bus_enable_q <= onehot(head.src);
          end else begin
            state_q      <= StIdle;
            bus_enable_q <= '0;
          end
          load_q <= '0;
        end
        StDrive: begin
          if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
            state_q <= StLoad;
            load_q  <= dst_q;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StLoad: begin
          state_q      <= StRelease;
          bus_enable_q <= '0;
          load_q       <= '0;
          done_q       <= 1'b1;
        end
        default: begin
          state_q      <= StIdle;
          bus_enable_q <= '0;
          load_q       <= '0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.bus_enable = bus_enable_q;
  assign bus.load       = load_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != StIdle) || !fifo_empty;

`ifndef SYNTHESIS
  a_single_driver : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus_enable_q));
  a_load_has_driver : assert property (@(posedge clk) disable iff (reset)
    (load_q != '0) |-> (bus_enable_q != '0));
  a_no_self_load : assert property (@(posedge clk) disable iff (reset)
    (load_q & bus_enable_q) == '0);
`endif

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench for bus_transfer_sequencer: a 4-register / settle-1 instance and a
// 3-register / settle-6 instance (used for out-of-range source and FIFO back-pressure).
module tb_bus_transfer_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_transfer_sequencer_if #(.NUM_REGS(4)) bus4 ();
  bus_transfer_sequencer_if #(.NUM_REGS(3)) bus3 ();

  bus_transfer_sequencer #(
    .NUM_REGS      (4),
    .FIFO_DEPTH    (4),
    .SETTLE_CYCLES (1)
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  bus_transfer_sequencer #(
    .NUM_REGS      (3),
    .FIFO_DEPTH    (4),
    .SETTLE_CYCLES (6)
  ) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observers: done pulses, strobe invariants, and the LOAD log of the 3-register instance.
  int         done4_cnt = 0;
  int         done3_cnt = 0;
  int         viol      = 0;
  logic [5:0] log3 [$];

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus4.done === 1'b1) done4_cnt++;
      if (bus3.done === 1'b1) done3_cnt++;
      if ($countones(bus4.bus_enable) > 1 || (bus4.load & bus4.bus_enable) != 0 ||
          (bus4.load != 0 && bus4.bus_enable == 0)) viol++;
      if ($countones(bus3.bus_enable) > 1 || (bus3.load & bus3.bus_enable) != 0 ||
          (bus3.load != 0 && bus3.bus_enable == 0)) viol++;
      if (bus3.load != 0) log3.push_back({bus3.bus_enable, bus3.load});
    end
  end

  logic [1:0] c3_src [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
  logic [2:0] c3_dst [6] = '{3'b010, 3'b100, 3'b001, 3'b110, 3'b101, 3'b011};

  initial begin
    int         d0;
    logic       ready_after [6];
    logic [2:0] oh;
    bit         acc;
    bit         got;

    reset = 1'b0;
    bus4.cmd_valid = 1'b0; bus4.cmd_src = '0; bus4.cmd_dst = '0;
    bus3.cmd_valid = 1'b0; bus3.cmd_src = '0; bus3.cmd_dst = '0;
    #1 reset = 1'b1;

    // Reset held with a command offered: nothing moves, nothing is queued.
    bus4.cmd_valid = 1'b1; bus4.cmd_src = 2'd0; bus4.cmd_dst = 4'b0010;
    bus3.cmd_valid = 1'b1; bus3.cmd_src = 2'd0; bus3.cmd_dst = 3'b010;
    repeat (3) step();
    check_eq("rst_bus_enable", 32'(bus4.bus_enable), 32'h0);
    check_eq("rst_load",       32'(bus4.load),       32'h0);
    check_eq("rst_done",       32'(bus4.done),       32'h0);
    check_eq("rst_err",        32'(bus4.err),        32'h0);
    check_eq("rst_busy",       32'(bus4.busy),       32'h0);
    bus4.cmd_valid = 1'b0;
    bus3.cmd_valid = 1'b0;
    reset = 1'b0;
    step();
    check_eq("rel_ready", 32'(bus4.cmd_ready), 32'h1);
    check_eq("rel_busy4", 32'(bus4.busy),      32'h0);
    check_eq("rel_busy3", 32'(bus3.busy),      32'h0);

    // Single move src=0 -> dst 0010.
    bus4.cmd_valid = 1'b1; bus4.cmd_src = 2'd0; bus4.cmd_dst = 4'b0010;
    step();
    bus4.cmd_valid = 1'b0;
    check_eq("s_e0_busy", 32'(bus4.busy),       32'h1);
    check_eq("s_e0_be",   32'(bus4.bus_enable), 32'h0);
    check_eq("s_e0_err",  32'(bus4.err),        32'h0);
    step();
    check_eq("s_e1_be",   32'(bus4.bus_enable), 32'b0001);
    check_eq("s_e1_load", 32'(bus4.load),       32'h0);
    step();
    check_eq("s_e2_be",   32'(bus4.bus_enable), 32'b0001);
    check_eq("s_e2_load", 32'(bus4.load),       32'b0010);
    step();
    check_eq("s_e3_be",   32'(bus4.bus_enable), 32'h0);
    check_eq("s_e3_load", 32'(bus4.load),       32'h0);
    check_eq("s_e3_done", 32'(bus4.done),       32'h1);
    step();
    check_eq("s_e4_done", 32'(bus4.done),       32'h0);
    check_eq("s_e4_busy", 32'(bus4.busy),       32'h0);

    // Back-to-back multicast: (1 -> 1100) then (3 -> 0001) on consecutive cycles.
    bus4.cmd_valid = 1'b1; bus4.cmd_src = 2'd1; bus4.cmd_dst = 4'b1100;
    step();
    bus4.cmd_src = 2'd3; bus4.cmd_dst = 4'b0001;
    step();
    bus4.cmd_valid = 1'b0;
    check_eq("b_e1_be",   32'(bus4.bus_enable), 32'b0010);
    step();
    check_eq("b_e2_load", 32'(bus4.load),       32'b1100);
    check_eq("b_e2_be",   32'(bus4.bus_enable), 32'b0010);
    step();
    check_eq("b_e3_dead", 32'({bus4.bus_enable, bus4.load}), 32'h0);
    check_eq("b_e3_done", 32'(bus4.done),       32'h1);
    step();
    check_eq("b_e4_be",   32'(bus4.bus_enable), 32'b1000);
    check_eq("b_e4_load", 32'(bus4.load),       32'h0);
    step();
    check_eq("b_e5_load", 32'(bus4.load),       32'b0001);
    step();
    check_eq("b_e6_done", 32'(bus4.done),       32'h1);
    check_eq("b_e6_be",   32'(bus4.bus_enable), 32'h0);
    step();
    check_eq("b_e7_busy", 32'(bus4.busy),       32'h0);
    check_eq("b_done_cnt", 32'(done4_cnt),      32'd3);

    // Rejects: destination includes source, empty destination, source out of range.
    bus4.cmd_valid = 1'b1; bus4.cmd_src = 2'd2; bus4.cmd_dst = 4'b0100;
    step();
    bus4.cmd_valid = 1'b0;
    check_eq("r_self_err",   32'(bus4.err),        32'h1);
    check_eq("r_self_busy",  32'(bus4.busy),       32'h0);
    check_eq("r_self_ready", 32'(bus4.cmd_ready),  32'h1);
    step();
    check_eq("r_self_err_end", 32'(bus4.err),      32'h0);
    check_eq("r_self_strobes", 32'({bus4.bus_enable, bus4.load}), 32'h0);
    check_eq("r_self_busy2", 32'(bus4.busy),       32'h0);
    bus4.cmd_valid = 1'b1; bus4.cmd_src = 2'd1; bus4.cmd_dst = 4'b0000;
    step();
    bus4.cmd_valid = 1'b0;
    check_eq("r_zero_err",  32'(bus4.err),  32'h1);
    check_eq("r_zero_busy", 32'(bus4.busy), 32'h0);
    bus3.cmd_valid = 1'b1; bus3.cmd_src = 2'd3; bus3.cmd_dst = 3'b001;
    step();
    bus3.cmd_valid = 1'b0;
    check_eq("r_range_err",  32'(bus3.err),  32'h1);
    check_eq("r_range_busy", 32'(bus3.busy), 32'h0);
    step();
    check_eq("r_range_strobes", 32'({bus3.bus_enable, bus3.load}), 32'h0);

    // FIFO back-pressure on the slow instance: six commands, the first one stalls in DRIVE.
    log3.delete();
    d0 = done3_cnt;
    for (int i = 0; i < 6; i++) begin
      bus3.cmd_valid = 1'b1; bus3.cmd_src = c3_src[i]; bus3.cmd_dst = c3_dst[i];
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
        acc = bus3.cmd_ready;
        step();
        got = acc;
      end
      check_eq($sformatf("f_accept%0d", i), 32'(got), 32'h1);
      ready_after[i] = bus3.cmd_ready;
    end
    bus3.cmd_valid = 1'b0;
    check_eq("f_ready_after3", 32'(ready_after[3]), 32'h1);
    check_eq("f_ready_after4", 32'(ready_after[4]), 32'h0);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      step();
      got = !bus3.busy;
    end
    check_eq("f_drain", 32'(got), 32'h1);
    check_eq("f_done_cnt", 32'(done3_cnt - d0), 32'd6);
    check_eq("f_log_size", 32'(log3.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      oh = 3'b001 << c3_src[i];
      if (i < log3.size())
        check_eq($sformatf("f_order%0d", i), 32'(log3[i]), 32'({oh, c3_dst[i]}));
    end

    // Reset during LOAD with a second command still queued.
    bus4.cmd_valid = 1'b1; bus4.cmd_src = 2'd2; bus4.cmd_dst = 4'b0001;
    step();
    bus4.cmd_src = 2'd0; bus4.cmd_dst = 4'b1000;
    step();
    bus4.cmd_valid = 1'b0;
    step();
    check_eq("m_load", 32'(bus4.load),       32'b0001);
    check_eq("m_be",   32'(bus4.bus_enable), 32'b0100);
    d0 = done4_cnt;
    #2 reset = 1'b1;
    #1;
    check_eq("m_async_load", 32'(bus4.load),       32'h0);
    check_eq("m_async_be",   32'(bus4.bus_enable), 32'h0);
    step();
    check_eq("m_rst_done", 32'(bus4.done), 32'h0);
    reset = 1'b0;
    step();
    check_eq("m_busy",  32'(bus4.busy),      32'h0);
    check_eq("m_ready", 32'(bus4.cmd_ready), 32'h1);
    step();
    check_eq("m_idle_strobes", 32'({bus4.bus_enable, bus4.load}), 32'h0);
    check_eq("m_no_done", 32'(done4_cnt - d0), 32'd0);

    check_eq("invariants", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_transfer_sequencer.md
Name: bus_transfer_sequencer

Overview:
- Sequences register-to-register moves over the shared 8-bit internal data bus.
- Drives the per-register bus_enable (output-to-bus) and load (capture-from-bus) strobes of NUM_REGS register instances.
- Accepts transfer commands through a valid/ready port and buffers them in a small FIFO.
- Guarantees at most one bus driver at any time, with a dead cycle between transfers.

Parameters:
- NUM_REGS, 4: number of bus-attached registers; legal range 2..16.
- FIFO_DEPTH, 4: command queue depth; power of two, at least 2.
- SETTLE_CYCLES, 1: cycles bus_enable is held before load is strobed; at least 1.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_src  in  $clog2(NUM_REGS)  index of the source register.
- cmd_dst  in  NUM_REGS  bitmask of destination registers; multicast allowed.
- bus_enable  out  NUM_REGS  per-register bus-drive strobe; at most one bit set.
- load  out  NUM_REGS  per-register load strobe.
- busy  out  1  a transfer is in progress or the queue is non-empty.
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (async assert): bus_enable=0, load=0, done=0, err=0, busy=0, FIFO emptied, state=IDLE. Outputs go low immediately, without waiting for clk. This holds even mid-transfer; an aborted transfer produces no done.
- cmd_ready = !fifo_full. Accept = cmd_valid && cmd_ready at a rising edge. No push-while-full, even if a pop happens in the same cycle.
- Validation at accept. Reject if cmd_src >= NUM_REGS, or cmd_dst == 0, or cmd_dst[cmd_src] == 1.
  - A rejected command is not queued.
  - err is high for the one cycle after the accept edge.
  - cmd_ready is unaffected by a rejection.
- FSM states: IDLE, DRIVE, LOAD, RELEASE.
  - IDLE: all strobes 0. If the FIFO is non-empty, pop the head into the src/dst holding registers and go to DRIVE.
  - DRIVE: bus_enable = onehot(src), load = 0. Stay SETTLE_CYCLES cycles (internal counter), then go to LOAD.
  - LOAD: bus_enable = onehot(src), load = dst, for exactly one cycle. Then go to RELEASE.
  - RELEASE: all strobes 0 (bus dead cycle), done = 1. If the FIFO is non-empty, pop and go to DRIVE; otherwise go to IDLE.
- All strobe outputs are registered (decoded from the next-state/holding registers), so there are no glitches.
- Latency, SETTLE_CYCLES=1, command accepted at edge E0 into an empty idle block:
  - after E1: DRIVE.
  - after E2: LOAD.
  - after E3: RELEASE, done.
  - after E4: IDLE.
- Throughput: back-to-back transfers take SETTLE_CYCLES+2 cycles each. The dead RELEASE cycle always separates two drivers.
- Simultaneous push and pop in the same cycle on a non-full FIFO: both happen; the count is unchanged.
- A command accepted while the FIFO is empty and the FSM is in IDLE is popped at the next edge. There is no bypass path.
- busy = (state != IDLE) || !fifo_empty.
- Invariants, asserted in RTL under a simulation-only guard:
  - $onehot0(bus_enable).
  - (load != 0) implies (bus_enable != 0).
  - (load & bus_enable) == 0.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - the state enum typedef (IDLE/DRIVE/LOAD/RELEASE);
  - the command struct typedef {src, dst};
  - the localparam for the bus data width (8).
- One sub-module, cmd_fifo: synchronous FIFO, parameterised width and depth, async active-high reset, with full/empty flags. It instantiates only in this block.

Test Plan:
- Reset: hold reset=1 while cmd_valid=1 -> all outputs 0, cmd_ready=1 on release, nothing queued.
- Single move, src=0, dst=4'b0010, NUM_REGS=4:
  - bus_enable=4'b0001 for 2 cycles starting 1 cycle after accept;
  - load=4'b0010 in the 2nd of those cycles;
  - done in the following cycle, strobes 0.
- Back-to-back multicast, (src=1, dst=4'b1100) then (src=3, dst=4'b0001), pushed on consecutive cycles:
  - transfers start 3 cycles apart;
  - one all-zero RELEASE cycle between them;
  - two done pulses.
- Full FIFO: push 5 commands while stalled in the first transfer -> cmd_ready drops after the 4th queued entry, all 5 eventually execute in order.
- Rejects:
  - src=2, dst=4'b0100 -> err pulse, no strobes, busy stays 0;
  - dst=0 -> err;
  - NUM_REGS=3 with src=3 -> err.
- Mid-transfer reset: assert reset during LOAD -> load and bus_enable drop immediately (same cycle), no done, FIFO empty after release.
